fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_controller.sv | 94 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch front-end types: defaults, FSM state encoding, buffer entry.
// ERR exists only when FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int          FETCH_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    ERR  = 2'd3
`endif
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: in-order fetch buffer with a registered head entry and synchronous flush.
// Latency: push to head visible 1 cycle; head holds its last value while empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_nxt;
  logic [AW:0]   count;
  logic [AW:0]   remain;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);
  assign remain  = count - (AW+1)'(do_pop);
  assign rd_nxt  = rd_ptr + AW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      count <= remain + (AW+1)'(do_push);
      // Older entries take the head before a same-cycle push; an empty buffer keeps the stale head.
      if (remain != '0) head <= mem[rd_nxt];
      else if (do_push) head <= push_dat;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Purpose: sequential instruction fetch with redirect/halt; FETCH_ALIGN_CHECK_EN traps misaligned redirects.
// Latency: fetch to inst_valid 1 cycle; first instruction 2 cycles after reset release.
// Backpressure: inst_valid/inst_ready handshake; fetch stalls and pc holds while the buffer is full.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          FETCH_DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        misalign
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         full;
  logic         empty;
  logic         pop;
  logic         push;
  logic         flush;
  logic         live;
  fetch_entry_t head;

  assign imem_addr  = pc;
  assign inst_valid = ~empty;
  assign inst_data  = head.instr;
  assign inst_pc    = head.pc;
  assign pop        = inst_valid & inst_ready;

`ifdef FETCH_ALIGN_CHECK_EN
  logic bad_redirect;
  assign live         = (state != ERR);
  assign bad_redirect = redirect_valid & live & (redirect_pc[1:0] != 2'b00);
`else
  assign live     = 1'b1;
  assign misalign = 1'b0;
`endif

  assign flush = redirect_valid & live;
  assign push  = (state == RUN) & ~halt & ~redirect_valid & (~full | pop);

  fetch_fifo #(.DEPTH(FETCH_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat ({pc, imem_rdata}),
    .pop      (pop),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
    end else begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (bad_redirect) begin
        state    <= ERR;
        misalign <= 1'b1;
      end else
`endif
      if (flush) begin
        // Redirect wins over the normal transitions; halt still decides where we land.
        pc    <= redirect_pc & 32'hFFFF_FFFC;
        state <= halt ? HALT : RUN;
      end else begin
        if (push) pc <= pc + 32'd4;
        case (state)
          BOOT:    state <= RUN;
          RUN:     if (halt) state <= HALT;
          HALT:    if (!halt) state <= RUN;
          default: state <= state;
        endcase
      end
    end
  end

endmodule
